// File: rtl/nnacc_pkg.sv
// Shared types and default widths for the NN accelerator datapath.
// FIFOs, MAC stages and downstream consumers all import this package.
package nnacc_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ACC_WIDTH  = 72;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

endpackage

// File: rtl/mac_unit.sv
// Combinational signed multiply-accumulate. The first element of a vector
// replaces the accumulator, so no separate clear of acc is needed.
module mac_unit
  import nnacc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  input  logic        [ACC_WIDTH-1:0]  acc_in,
  input  logic                         first,
  output logic        [ACC_WIDTH-1:0]  acc_out
);

  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]    product_ext;

  // Signed cast widening sign-extends the full-width product.
  assign product     = a * b;
  assign product_ext = ACC_WIDTH'(product);
  assign acc_out     = first ? product_ext : acc_in + product_ext;

endmodule

// File: rtl/fifo_mac_stage.sv
// Dot-product stage: pops activation/weight pairs from two FWFT FIFOs,
// accumulates VEC_LEN signed products and hands the result downstream.
module fifo_mac_stage
  import nnacc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int VEC_LEN    = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [DATA_WIDTH-1:0] act_data,
  input  logic                  act_empty,
  output logic                  act_rd_en,
  input  logic [DATA_WIDTH-1:0] wgt_data,
  input  logic                  wgt_empty,
  output logic                  wgt_rd_en,
  input  logic                  clear,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy,
  output logic [15:0]           res_cnt
);

  localparam int CNT_WIDTH = $clog2(VEC_LEN) + 1;

  if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_bad_acc_width
    $error("fifo_mac_stage: ACC_WIDTH must be at least 2*DATA_WIDTH");
  end
  if (VEC_LEN < 1) begin : g_bad_vec_len
    $error("fifo_mac_stage: VEC_LEN must be at least 1");
  end

  state_t                 state;
  logic [CNT_WIDTH-1:0]   count;
  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH-1:0]   mac_sum;
  logic                   pop;
  logic                   last;

  // Reset gates the pop so the FIFOs are never drained while held in reset.
  assign pop       = sys_rst_n && (state == ST_ACC) && !act_empty && !wgt_empty && !clear;
  assign act_rd_en = pop;
  assign wgt_rd_en = pop;
  assign last      = (count == CNT_WIDTH'(VEC_LEN - 1));
  assign busy      = (state == ST_OUT) || (count != '0);

  mac_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .a      (act_data),
    .b      (wgt_data),
    .acc_in (acc),
    .first  (count == '0),
    .acc_out(mac_sum)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_ACC;
      count     <= '0;
      acc       <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      res_cnt   <= '0;
    end else if (clear) begin
      state     <= ST_ACC;
      count     <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (pop) begin
            acc <= mac_sum;
            if (last) begin
              res_data  <= mac_sum;
              res_valid <= 1'b1;
              state     <= ST_OUT;
              count     <= '0;
            end else begin
              count <= count + CNT_WIDTH'(1);
            end
          end
        end
        ST_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_cnt   <= res_cnt + 16'd1;
            state     <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_mac_stage.sv
// Directed bench for fifo_mac_stage with two modelled FWFT FIFOs
// (DATA_WIDTH=8, ACC_WIDTH=24, VEC_LEN=4).
module tb_fifo_mac_stage;

  localparam int DW = 8;
  localparam int AW = 24;
  localparam int VL = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic [DW-1:0] act_data;
  logic          act_empty;
  logic          act_rd_en;
  logic [DW-1:0] wgt_data;
  logic          wgt_empty;
  logic          wgt_rd_en;
  logic          clear;
  logic [AW-1:0] res_data;
  logic          res_valid;
  logic          res_ready;
  logic          busy;
  logic [15:0]   res_cnt;

  logic [DW-1:0] act_mem [64];
  logic [DW-1:0] wgt_mem [64];
  int act_head = 0;
  int act_tail = 0;
  int wgt_head = 0;
  int wgt_tail = 0;
  int pops = 0;
  logic flush = 1'b0;

  int checks = 0;
  int errors = 0;
  int p;

  always #5 sys_clk = ~sys_clk;

  assign act_empty = (act_head == act_tail);
  assign wgt_empty = (wgt_head == wgt_tail);
  assign act_data  = act_mem[act_head[5:0]];
  assign wgt_data  = wgt_mem[wgt_head[5:0]];

  // FIFO model: pop on rd_en at the clock edge; flush drops stale words.
  always @(posedge sys_clk) begin
    if (flush) begin
      act_head <= act_tail;
      wgt_head <= wgt_tail;
    end else begin
      if (act_rd_en) act_head <= act_head + 1;
      if (wgt_rd_en) wgt_head <= wgt_head + 1;
      if (act_rd_en) pops <= pops + 1;
    end
  end

  fifo_mac_stage #(
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW),
    .VEC_LEN   (VL)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .act_data (act_data),
    .act_empty(act_empty),
    .act_rd_en(act_rd_en),
    .wgt_data (wgt_data),
    .wgt_empty(wgt_empty),
    .wgt_rd_en(wgt_rd_en),
    .clear    (clear),
    .res_data (res_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .busy     (busy),
    .res_cnt  (res_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic pushAct(input logic [DW-1:0] v);
    act_mem[act_tail[5:0]] = v;
    act_tail++;
  endtask

  task automatic pushWgt(input logic [DW-1:0] v);
    wgt_mem[wgt_tail[5:0]] = v;
    wgt_tail++;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] a0, a1, a2, a3,
                               input logic [DW-1:0] w0, w1, w2, w3);
    pushAct(a0); pushAct(a1); pushAct(a2); pushAct(a3);
    pushWgt(w0); pushWgt(w1); pushWgt(w2); pushWgt(w3);
    #1;
  endtask

  task automatic waitValid(input int budget);
    int n;
    n = 0;
    while (!res_valid && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("valid_timeout", {31'd0, res_valid}, 32'd1);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    clear     = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(negedge sys_clk);
    checkOutput("rst_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst_cnt", {16'd0, res_cnt}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_data", {8'd0, res_data}, 32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Basic: four back-to-back pops, result the cycle after the last one.
    applyStimulus(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    for (int i = 0; i < VL; i++) begin
      checkOutput("basic_act_rd", {31'd0, act_rd_en}, 32'd1);
      checkOutput("basic_wgt_rd", {31'd0, wgt_rd_en}, 32'd1);
      checkOutput("basic_nvalid", {31'd0, res_valid}, 32'd0);
      @(negedge sys_clk);
    end
    checkOutput("basic_valid", {31'd0, res_valid}, 32'd1);
    checkOutput("basic_data", {8'd0, res_data}, 32'd70);
    checkOutput("basic_busy", {31'd0, busy}, 32'd1);
    @(negedge sys_clk);
    checkOutput("basic_hs_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("basic_cnt", {16'd0, res_cnt}, 32'd1);
    checkOutput("basic_idle", {31'd0, busy}, 32'd0);

    // Signed operands, result -24.
    applyStimulus(8'hFD, 8'h7F, 8'h80, 8'h01, 8'h07, 8'h02, 8'h02, 8'hFF);
    waitValid(10);
    checkOutput("signed_data", {8'd0, res_data}, 32'h00FFFFE8);
    @(negedge sys_clk);
    checkOutput("signed_cnt", {16'd0, res_cnt}, 32'd2);

    // Starvation: weight FIFO runs dry after two pairs.
    pushAct(8'd1); pushAct(8'd2); pushWgt(8'd5); pushWgt(8'd6);
    repeat (2) @(negedge sys_clk);
    pushAct(8'd3); pushAct(8'd4);
    #1;
    p = pops;
    for (int i = 0; i < 3; i++) begin
      checkOutput("starve_rd", {31'd0, act_rd_en}, 32'd0);
      checkOutput("starve_busy", {31'd0, busy}, 32'd1);
      @(negedge sys_clk);
    end
    checkOutput("starve_pops", pops, p);
    pushWgt(8'd7); pushWgt(8'd8);
    waitValid(10);
    checkOutput("starve_data", {8'd0, res_data}, 32'd70);
    @(negedge sys_clk);
    checkOutput("starve_cnt", {16'd0, res_cnt}, 32'd3);

    // Backpressure with an extra pair waiting behind the vector.
    res_ready = 1'b0;
    applyStimulus(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    pushAct(8'd1); pushWgt(8'd1);
    waitValid(10);
    p = pops;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", {31'd0, res_valid}, 32'd1);
      checkOutput("bp_data", {8'd0, res_data}, 32'd70);
      checkOutput("bp_rd", {31'd0, act_rd_en}, 32'd0);
      @(negedge sys_clk);
    end
    checkOutput("bp_pops", pops, p);
    res_ready = 1'b1;
    #1;
    checkOutput("bp_hs_rd", {31'd0, act_rd_en}, 32'd0);
    @(negedge sys_clk);
    checkOutput("bp_after_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("bp_after_cnt", {16'd0, res_cnt}, 32'd4);
    checkOutput("bp_resume_rd", {31'd0, act_rd_en}, 32'd1);
    @(negedge sys_clk);
    checkOutput("bp_partial_busy", {31'd0, busy}, 32'd1);
    clear = 1'b1;
    #1;
    checkOutput("bp_clear_rd", {31'd0, act_rd_en}, 32'd0);
    @(negedge sys_clk);
    clear = 1'b0;
    checkOutput("bp_clear_busy", {31'd0, busy}, 32'd0);

    // Abort after the second pop; leftover FIFO words are discarded.
    applyStimulus(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    repeat (2) @(negedge sys_clk);
    clear = 1'b1;
    #1;
    checkOutput("abort_rd", {31'd0, act_rd_en}, 32'd0);
    checkOutput("abort_wrd", {31'd0, wgt_rd_en}, 32'd0);
    p = pops;
    flush = 1'b1;
    @(negedge sys_clk);
    clear = 1'b0;
    flush = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_pops", pops, p);
    checkOutput("abort_cnt", {16'd0, res_cnt}, 32'd4);
    checkOutput("abort_old_data", {8'd0, res_data}, 32'd70);
    applyStimulus(8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2);
    waitValid(10);
    checkOutput("abort_data", {8'd0, res_data}, 32'd8);
    @(negedge sys_clk);
    checkOutput("abort_cnt2", {16'd0, res_cnt}, 32'd5);

    // Asynchronous reset while a result is pending.
    res_ready = 1'b0;
    applyStimulus(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    pushAct(8'd9); pushWgt(8'd9);
    waitValid(10);
    checkOutput("arst_pre_data", {8'd0, res_data}, 32'd70);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("arst_cnt", {16'd0, res_cnt}, 32'd0);
    checkOutput("arst_rd", {31'd0, act_rd_en}, 32'd0);
    checkOutput("arst_wrd", {31'd0, wgt_rd_en}, 32'd0);
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    flush = 1'b1;
    @(negedge sys_clk);
    flush = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    res_ready = 1'b1;
    applyStimulus(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    waitValid(10);
    checkOutput("arst_data", {8'd0, res_data}, 32'd70);
    @(negedge sys_clk);
    checkOutput("arst_cnt2", {16'd0, res_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
